// File: rtl/rst_seq_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encodings,
// reset-cause codes and a small helper for sizing the sequencing counter.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_LOCK  = 3'd1,
        REL_PERIPH = 3'd2,
        RUN        = 3'd3,
        SWRST      = 3'd4
    } rst_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_LOCK = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Synchronizer plus stability filter for a slow asynchronous input.
// The filtered output only follows the synchronized input after it has
// disagreed with the current filtered value for STABLE_CYCLES cycles in a row;
// any return to agreement restarts the count.
module rst_debounce #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 800000,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain: shift the raw input through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles and adopt the new level once the count completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            stable <= RESET_VALUE;
        end else if (synced != stable) begin
            if (cnt_q == CNT_LAST) begin
                stable <= synced;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Board-level reset sequencer. Holds the SoC in reset until the PLL has been
// locked for a qualified interval and the button is released, then releases
// the interconnect/peripherals before the CPU. A software request from the
// running SoC replays the reset pulse without re-qualifying lock. Lock loss or
// a button press aborts any active sequence back to HOLD.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES          = 2,
    parameter int DEBOUNCE_CYCLES      = 800000,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int PERIPH_TO_CPU_CYCLES = 16,
    parameter int SWRST_PULSE_CYCLES   = 32
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       btn_rst_n_i,
    input  logic       pll_locked_i,
    input  logic       swrst_req_i,
    output logic       swrst_ack_o,
    output logic       periph_arst_o,
    output logic       cpu_arst_o,
    output logic [1:0] rst_cause_o,
    output logic [2:0] rst_state_o
);

    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, PERIPH_TO_CPU_CYCLES, SWRST_PULSE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] P2C_LAST   = CNT_W'(PERIPH_TO_CPU_CYCLES - 1);
    localparam logic [CNT_W-1:0] SWRST_LAST = CNT_W'(SWRST_PULSE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] swrst_sync_q;
    logic                   lock_s;
    logic                   swrst_s;
    logic                   btn_db;

    rst_state_t       state_q;
    rst_state_t       state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       cause_next;
    logic             ack_next;

    assign lock_s      = lock_sync_q[SYNC_STAGES-1];
    assign swrst_s     = swrst_sync_q[SYNC_STAGES-1];
    assign rst_state_o = state_q;

    // The button starts out "pressed" so the SoC stays in reset until a
    // genuinely released level has been observed for the full debounce time.
    rst_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VALUE  (1'b0)
    ) u_btn_debounce (
        .clk   (clk_i),
        .rst_n (arst_n_i),
        .raw   (btn_rst_n_i),
        .stable(btn_db)
    );

    // Plain synchronizer chains for the PLL lock and the software request.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_sync_q  <= '0;
            swrst_sync_q <= '0;
        end else begin
            lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            swrst_sync_q <= {swrst_sync_q[SYNC_STAGES-2:0], swrst_req_i};
        end
    end

    // Next-state, counter and cause logic; aborts override every normal transition.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        cause_next = rst_cause_o;
        ack_next   = 1'b0;

        case (state_q)
            HOLD: begin
                cnt_next = '0;
                if (lock_s && btn_db) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    state_next = REL_PERIPH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            REL_PERIPH: begin
                if (cnt_q == P2C_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_next = '0;
                if (swrst_s) begin
                    state_next = SWRST;
                    cause_next = CAUSE_SW;
                    ack_next   = 1'b1;
                end
            end
            SWRST: begin
                if (cnt_q == SWRST_LAST) begin
                    state_next = REL_PERIPH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
        endcase

        if (state_q != HOLD) begin
            if (!lock_s) begin
                state_next = HOLD;
                cnt_next   = '0;
                cause_next = CAUSE_LOCK;
                ack_next   = 1'b0;
            end else if (!btn_db) begin
                state_next = HOLD;
                cnt_next   = '0;
                cause_next = CAUSE_BTN;
                ack_next   = 1'b0;
            end
        end
    end

    // State, counter and registered outputs, all decoded from the next state.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q       <= HOLD;
            cnt_q         <= '0;
            periph_arst_o <= 1'b1;
            cpu_arst_o    <= 1'b1;
            swrst_ack_o   <= 1'b0;
            rst_cause_o   <= CAUSE_POR;
        end else begin
            state_q       <= state_next;
            cnt_q         <= cnt_next;
            periph_arst_o <= (state_next != REL_PERIPH) && (state_next != RUN);
            cpu_arst_o    <= (state_next != RUN);
            swrst_ack_o   <= ack_next;
            rst_cause_o   <= cause_next;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small sequencing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rst_sequencer;

    logic       clk_i;
    logic       arst_n_i;
    logic       btn_rst_n_i;
    logic       pll_locked_i;
    logic       swrst_req_i;
    logic       swrst_ack_o;
    logic       periph_arst_o;
    logic       cpu_arst_o;
    logic [1:0] rst_cause_o;
    logic [2:0] rst_state_o;

    int compared   = 0;
    int mismatched = 0;

    rst_sequencer #(
        .SYNC_STAGES         (2),
        .DEBOUNCE_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .PERIPH_TO_CPU_CYCLES(3),
        .SWRST_PULSE_CYCLES  (5)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .btn_rst_n_i  (btn_rst_n_i),
        .pll_locked_i (pll_locked_i),
        .swrst_req_i  (swrst_req_i),
        .swrst_ack_o  (swrst_ack_o),
        .periph_arst_o(periph_arst_o),
        .cpu_arst_o   (cpu_arst_o),
        .rst_cause_o  (rst_cause_o),
        .rst_state_o  (rst_state_o)
    );

    // Free-running system clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Safety net so a broken design can never stall the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic apply_stimulus(input logic btn, input logic lock, input logic swrst);
        btn_rst_n_i  = btn;
        pll_locked_i = lock;
        swrst_req_i  = swrst;
    endtask

    task automatic compare_field(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [2:0] exp_state, input logic exp_periph,
                                input logic exp_cpu, input logic exp_ack, input logic [1:0] exp_cause);
        compare_field({tag, ".state"},  rst_state_o,          exp_state);
        compare_field({tag, ".periph"}, {2'b0, periph_arst_o}, {2'b0, exp_periph});
        compare_field({tag, ".cpu"},    {2'b0, cpu_arst_o},    {2'b0, exp_cpu});
        compare_field({tag, ".ack"},    {2'b0, swrst_ack_o},   {2'b0, exp_ack});
        compare_field({tag, ".cause"},  {1'b0, rst_cause_o},   {1'b0, exp_cause});
    endtask

    // Linear sequence of directed steps; expected values derived by hand from
    // sync=2, debounce=4, lock-stable=8, periph-to-cpu=3, swrst pulse=5.
    initial begin
        apply_stimulus(1'b1, 1'b1, 1'b0);
        arst_n_i = 1'b1;
        #2 arst_n_i = 1'b0;
        tick(2);
        check_output("por_reset", 3'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        arst_n_i = 1'b1;

        // Power-on: debounce finishes after 6 edges, WAIT_LOCK on the 7th.
        tick(6);  check_output("por_db_hold",   3'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(1);  check_output("por_wait_lock", 3'd1, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(7);  check_output("por_lock_7",    3'd1, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(1);  check_output("por_rel",       3'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        tick(2);  check_output("por_rel_last",  3'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        tick(1);  check_output("por_run",       3'd3, 1'b0, 1'b0, 1'b0, 2'd0);

        // Lock loss in RUN reaches HOLD three edges later.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick(2);  check_output("lockloss_pre",  3'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(1);  check_output("lockloss_hold", 3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(2);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(2);  check_output("relock_hold",   3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(1);  check_output("relock_wait",   3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(1);  check_output("glitch_cnt5",   3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(1);  check_output("glitch_hold",   3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(1);  check_output("glitch_rewait", 3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(7);  check_output("glitch_full7",  3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(1);  check_output("glitch_rel",    3'd2, 1'b0, 1'b1, 1'b0, 2'd2);
        tick(3);  check_output("glitch_run",    3'd3, 1'b0, 1'b0, 1'b0, 2'd2);

        // Short button glitch is filtered out.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        tick(3);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(8);  check_output("btn_short",     3'd3, 1'b0, 1'b0, 1'b0, 2'd2);

        // Real press: HOLD seven edges after the button falls.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        tick(6);  check_output("btn_pre",       3'd3, 1'b0, 1'b0, 1'b0, 2'd2);
        tick(1);  check_output("btn_hold",      3'd0, 1'b1, 1'b1, 1'b0, 2'd1);
        tick(1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(6);  check_output("btn_rel_hold",  3'd0, 1'b1, 1'b1, 1'b0, 2'd1);
        tick(1);  check_output("btn_rel_wait",  3'd1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick(11); check_output("btn_rel_run",   3'd3, 1'b0, 1'b0, 1'b0, 2'd1);

        // Software reset: one-cycle ack, five-cycle pulse, then staged release.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        tick(2);  check_output("sw_pre",        3'd3, 1'b0, 1'b0, 1'b0, 2'd1);
        tick(1);  check_output("sw_ack",        3'd4, 1'b1, 1'b1, 1'b1, 2'd3);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(1);  check_output("sw_ack_drop",   3'd4, 1'b1, 1'b1, 1'b0, 2'd3);
        tick(3);  check_output("sw_pulse_end",  3'd4, 1'b1, 1'b1, 1'b0, 2'd3);
        tick(1);  check_output("sw_rel",        3'd2, 1'b0, 1'b1, 1'b0, 2'd3);
        tick(2);  check_output("sw_rel_last",   3'd2, 1'b0, 1'b1, 1'b0, 2'd3);
        tick(1);  check_output("sw_run",        3'd3, 1'b0, 1'b0, 1'b0, 2'd3);
        tick(4);  check_output("sw_run_stay",   3'd3, 1'b0, 1'b0, 1'b0, 2'd3);

        // Request raised together with lock loss: abort wins, HOLD ignores request.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        tick(2);  check_output("swhold_pre",    3'd3, 1'b0, 1'b0, 1'b0, 2'd3);
        tick(1);  check_output("swhold_enter",  3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_output("swhold_idle", 3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(3);  check_output("swhold_wait",   3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(11); check_output("swhold_run",    3'd3, 1'b0, 1'b0, 1'b0, 2'd2);

        // Lock loss and debounced press land in the same REL_PERIPH cycle.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        tick(3);  check_output("both_sw",       3'd4, 1'b1, 1'b1, 1'b1, 2'd3);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        tick(4);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        tick(1);  check_output("both_rel",      3'd2, 1'b0, 1'b1, 1'b0, 2'd3);
        tick(1);  check_output("both_rel2",     3'd2, 1'b0, 1'b1, 1'b0, 2'd3);
        tick(1);  check_output("both_hold",     3'd0, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(7);  check_output("both_wait",     3'd1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(11); check_output("both_run",      3'd3, 1'b0, 1'b0, 1'b0, 2'd2);

        // Asynchronous reset in the middle of a software reset pulse.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        tick(3);  check_output("arst_sw",       3'd4, 1'b1, 1'b1, 1'b1, 2'd3);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        tick(2);  check_output("arst_mid",      3'd4, 1'b1, 1'b1, 1'b0, 2'd3);
        arst_n_i = 1'b0;
        #1;       check_output("arst_async",    3'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(2);  check_output("arst_held",     3'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        arst_n_i = 1'b1;
        tick(6);  check_output("arst_db_hold",  3'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(1);  check_output("arst_wait",     3'd1, 1'b1, 1'b1, 1'b0, 2'd0);
        tick(8);  check_output("arst_rel",      3'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        tick(3);  check_output("arst_run",      3'd3, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Board-level reset controller between the raw board reset button, the PLL lock output and the sigma SoC.
- Debounces the button and synchronizes PLL lock; lock must be stable before release.
- Releases peripheral/interconnect reset first, then CPU reset; services a software-reset request from the SoC.
- Runs on the system clock; outputs are active-high resets that drive the SoC arst_i inputs.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (btn, lock, swrst_req); must be >=2.
- DEBOUNCE_CYCLES, 800000, consecutive stable cycles required before the debounced button changes.
- LOCK_STABLE_CYCLES, 1024, cycles lock must stay high in WAIT_LOCK before peripherals are released.
- PERIPH_TO_CPU_CYCLES, 16, cycles between periph_arst_o and cpu_arst_o deassertion.
- SWRST_PULSE_CYCLES, 32, cycles both resets are held for a software reset.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous active-low reset
- btn_rst_n_i  in  1  raw button, async, 0 = pressed
- pll_locked_i  in  1  PLL lock, async
- swrst_req_i  in  1  software reset request, level, held by requester until ack
- swrst_ack_o  out  1  one-cycle pulse when a software reset is accepted
- periph_arst_o  out  1  active-high reset for interconnect/peripherals
- cpu_arst_o  out  1  active-high reset for the CPU
- rst_cause_o  out  2  0 POR, 1 button, 2 lock loss, 3 software; sticky
- rst_state_o  out  3  current FSM state encoding, for debug/LED

Behaviour:
- Reset (arst_n_i=0, async): state=HOLD; periph_arst_o=1; cpu_arst_o=1; swrst_ack_o=0; rst_cause_o=0; all counters=0; synchronizer flops=0; debounced button=pressed.
- All outputs are registered.
- Inputs pass SYNC_STAGES flops; btn_s, lock_s and swrst_s denote the synchronized values.
- Debounce: btn_db changes to btn_s only after btn_s differs from btn_db for DEBOUNCE_CYCLES consecutive cycles. Any glitch back clears the counter.
- Encodings: HOLD=0, WAIT_LOCK=1, REL_PERIPH=2, RUN=3, SWRST=4.
- Abort rule, highest priority, evaluated in every state except HOLD:
  - lock_s=0 -> HOLD, cause=2.
  - Otherwise btn_db pressed -> HOLD, cause=1.
  - If both occur in the same cycle, cause=2.
- HOLD: periph=1, cpu=1. Go to WAIT_LOCK when lock_s=1 and btn_db released. Counter cleared.
- WAIT_LOCK: periph=1, cpu=1. Counter increments each cycle; at count LOCK_STABLE_CYCLES-1 go to REL_PERIPH and clear counter. periph deasserts on the cycle after exactly LOCK_STABLE_CYCLES cycles in WAIT_LOCK.
- REL_PERIPH: periph=0, cpu=1. After PERIPH_TO_CPU_CYCLES cycles go to RUN; cpu deasserts then.
- RUN: both 0. If swrst_s=1: go to SWRST, cause=3, swrst_ack_o=1 for exactly that one cycle.
- SWRST: both 1. After SWRST_PULSE_CYCLES cycles go to REL_PERIPH; lock is already qualified, so WAIT_LOCK is skipped.
- swrst_s is ignored outside RUN.
- If swrst_s is still high when RUN is re-entered, a new SWRST is taken. The requester must drop the request after the ack; the SoC loses this state anyway because it is reset.
- Abort during SWRST or REL_PERIPH: go to HOLD, cause overwritten per the abort rule.
- Counters are sized $clog2(max param)+1 and never wrap; they saturate/clear on state exit.
- Parameter value 1 is legal: one cycle in that state.
- rst_cause_o updates only on a transition into HOLD or SWRST; it holds through RUN.

Decomposition:
- Package rst_seq_pkg: state enum localparams (HOLD..SWRST) and cause codes (CAUSE_POR/BTN/LOCK/SW).
- One sub-module, rst_debounce: synchronizer plus stability counter, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES, reset value is a parameter.
- Lock and swrst synchronizers are plain flop chains inside the top.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE=4, LOCK_STABLE=8, P2C=3, SWRST_PULSE=5.
- POR with lock=1 and button released from t=0:
  - btn_db releases after 2+4 cycles.
  - periph_arst_o falls 8 cycles after WAIT_LOCK entry; cpu_arst_o falls 3 cycles later.
  - rst_cause_o=0.
- Lock drops for 1 cycle in WAIT_LOCK at count 5 -> HOLD, counter restarts, cause=2. Full 8-cycle count is required after lock returns.
- Button glitch low for 3 cycles in RUN -> no reset. Low for 4+ cycles -> both resets assert within 2+4+1 cycles, cause=1.
- swrst_req=1 in RUN:
  - Ack pulse width 1, both resets high for 5 cycles, then periph low, cpu low 3 cycles later, cause=3.
  - swrst_req held in HOLD is ignored and gives no ack.
- Lock loss and button press same cycle in REL_PERIPH -> HOLD, cause=2.
- arst_n_i asserted mid-SWRST -> all outputs at reset values immediately (async), cause=0, then normal POR sequence.
